// File: rtl/resumption_ctx_scheduler.sv
// resumption_ctx_scheduler: round-robin time-multiplexing of one resumption core among N_CTX contexts
module resumption_ctx_scheduler #(
  parameter int N_CTX    = 4,
  parameter int IN_W     = 1,
  parameter int OUT_W    = 1,
  parameter int TAG_W    = 1,
  parameter int TAG_INIT = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_CTX-1:0]           req_valid,
  input  logic [N_CTX*IN_W-1:0]      req_data,
  output logic [N_CTX-1:0]           req_ready,
  input  logic [N_CTX-1:0]           ctx_restart,
  output logic [TAG_W-1:0]           core_tag,
  output logic [IN_W-1:0]            core_in,
  input  logic [OUT_W-1:0]           core_out,
  input  logic [TAG_W-1:0]           core_tag_next,
  input  logic                       core_continue,
  output logic                       resp_valid,
  output logic [$clog2(N_CTX)-1:0]   resp_ctx,
  output logic [OUT_W-1:0]           resp_data,
  output logic                       resp_halted,
  output logic [N_CTX-1:0]           halted,
  output logic                       busy,
  output logic [15:0]                step_count
);
  localparam int PW = $clog2(N_CTX);
  logic [TAG_W-1:0] r_tag [N_CTX];
  logic [N_CTX-1:0] r_halted;
  logic [PW-1:0]    r_ptr;
  logic             r_resp_valid;
  logic [PW-1:0]    r_resp_ctx;
  logic [OUT_W-1:0] r_resp_data;
  logic             r_resp_halted;
  logic [15:0]      r_steps;
  logic [N_CTX-1:0] w_elig;
  logic [PW-1:0]    w_g;
  logic [PW-1:0]    w_idx;
  logic             w_any;
  assign w_elig = req_valid & ~r_halted & ~ctx_restart;
  // scan from farthest to nearest so the index closest to r_ptr wins
  always_comb begin
    w_any = 1'b0;
    w_g   = '0;
    w_idx = '0;
    for (int k = N_CTX - 1; k >= 0; k--) begin
      w_idx = r_ptr + PW'(k);
      if (w_elig[w_idx]) begin
        w_any = 1'b1;
        w_g   = w_idx;
      end
    end
  end
  assign busy        = |w_elig;
  assign req_ready   = w_any ? N_CTX'(1) << w_g : '0;
  assign core_tag    = w_any ? r_tag[w_g] : '0;
  assign core_in     = w_any ? req_data[int'(w_g)*IN_W +: IN_W] : '0;
  assign halted      = r_halted;
  assign resp_valid  = r_resp_valid;
  assign resp_ctx    = r_resp_ctx;
  assign resp_data   = r_resp_data;
  assign resp_halted = r_resp_halted;
  assign step_count  = r_steps;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CTX; i++) r_tag[i] <= TAG_W'(TAG_INIT);
      r_halted      <= '0;
      r_ptr         <= '0;
      r_resp_valid  <= 1'b0;
      r_resp_ctx    <= '0;
      r_resp_data   <= '0;
      r_resp_halted <= 1'b0;
      r_steps       <= '0;
    end else begin
      for (int i = 0; i < N_CTX; i++) begin
        if (ctx_restart[i]) begin
          r_tag[i]    <= TAG_W'(TAG_INIT);
          r_halted[i] <= 1'b0;
        end else if (w_any && w_g == PW'(i)) begin
          r_tag[i]    <= core_tag_next;
          r_halted[i] <= ~core_continue;
        end
      end
      r_resp_valid <= w_any;
      if (w_any) begin
        r_resp_ctx    <= w_g;
        r_resp_data   <= core_out;
        r_resp_halted <= ~core_continue;
        r_ptr         <= w_g + PW'(1);
        r_steps       <= r_steps + 16'(r_steps != 16'hFFFF);
      end
    end
  end
endmodule

// File: tb/tb_resumption_ctx_scheduler.sv
// tb_resumption_ctx_scheduler: directed checks of arbitration, commit, halt, restart, reset and saturation
module tb_resumption_ctx_scheduler;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_ready, ctx_restart, halted, req_data;
  logic        core_tag, core_in, core_out, core_tag_next, core_continue;
  logic        resp_valid, resp_data, resp_halted, busy, halt_mode;
  logic [1:0]  resp_ctx;
  logic [15:0] step_count;
  int          n_tests = 0;
  int          n_fail = 0;
  always #5 clk = ~clk;
  // reference core: output = tag, next tag = ~tag, optionally finishes when tag is 0
  assign core_out      = core_tag;
  assign core_tag_next = ~core_tag;
  assign core_continue = halt_mode ? core_tag : 1'b1;
  resumption_ctx_scheduler #(.N_CTX(4), .IN_W(1), .OUT_W(1), .TAG_W(1), .TAG_INIT(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .ctx_restart(ctx_restart), .core_tag(core_tag), .core_in(core_in), .core_out(core_out),
    .core_tag_next(core_tag_next), .core_continue(core_continue), .resp_valid(resp_valid),
    .resp_ctx(resp_ctx), .resp_data(resp_data), .resp_halted(resp_halted), .halted(halted),
    .busy(busy), .step_count(step_count)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; ctx_restart = '0; halt_mode = 1'b0;
    repeat (2) tick;
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_ctx", 32'(resp_ctx), 0);
    chk("rst_resp_data", 32'(resp_data), 0);
    chk("rst_resp_halted", 32'(resp_halted), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_steps", 32'(step_count), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0; req_valid = 4'hF; req_data = 4'b1010;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rr_ready", 32'(req_ready), 32'(1) << (k % 4));
      chk("rr_core_tag", 32'(core_tag), 32'(k < 4));
      chk("rr_core_in", 32'(core_in), 32'(req_data[k % 4]));
      tick;
      chk("rr_resp_valid", 32'(resp_valid), 1);
      chk("rr_resp_ctx", 32'(resp_ctx), 32'(k % 4));
      chk("rr_resp_data", 32'(resp_data), 32'(k < 4));
    end
    chk("rr_steps", 32'(step_count), 8);
    req_valid = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("solo_ready", 32'(req_ready), 4);
      tick;
      chk("solo_resp_data", 32'(resp_data), 32'(k % 2 == 0));
    end
    req_valid = 4'b1010;
    #1;
    chk("ptr3_ready", 32'(req_ready), 8);
    tick;
    chk("ptr3_resp_ctx", 32'(resp_ctx), 3);
    #1;
    chk("wrap_ready", 32'(req_ready), 2);
    tick;
    chk("wrap_resp_ctx", 32'(resp_ctx), 1);
    chk("mid_steps", 32'(step_count), 13);
    halt_mode = 1'b1; req_valid = 4'b0001;
    #1;
    chk("h1_ready", 32'(req_ready), 1);
    tick;
    chk("h1_resp_halted", 32'(resp_halted), 0);
    #1;
    chk("h2_ready", 32'(req_ready), 1);
    tick;
    chk("h2_resp_halted", 32'(resp_halted), 1);
    chk("h2_halted", 32'(halted), 1);
    #1;
    chk("halted_ready", 32'(req_ready), 0);
    chk("halted_busy", 32'(busy), 0);
    tick;
    chk("halted_resp_valid", 32'(resp_valid), 0);
    chk("halted_steps", 32'(step_count), 15);
    ctx_restart = 4'b0001;
    #1;
    chk("restart_ready", 32'(req_ready), 0);
    tick;
    chk("restart_halted", 32'(halted), 0);
    chk("restart_resp_valid", 32'(resp_valid), 0);
    ctx_restart = '0;
    #1;
    chk("post_restart_ready", 32'(req_ready), 1);
    chk("post_restart_tag", 32'(core_tag), 1);
    tick;
    chk("post_restart_resp_valid", 32'(resp_valid), 1);
    chk("post_restart_resp_ctx", 32'(resp_ctx), 0);
    halt_mode = 1'b0; req_valid = 4'b0011;
    #1;
    chk("pre_rst_ready", 32'(req_ready), 2);
    rst = 1'b1;
    tick;
    chk("midrst_resp_valid", 32'(resp_valid), 0);
    chk("midrst_steps", 32'(step_count), 0);
    chk("midrst_halted", 32'(halted), 0);
    rst = 1'b0; req_valid = 4'hF;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("midrst_ready", 32'(req_ready), 32'(1) << k);
      chk("midrst_tag", 32'(core_tag), 1);
      tick;
    end
    chk("midrst_steps4", 32'(step_count), 4);
    repeat (65530) tick;
    chk("sat_fffe", 32'(step_count), 32'hFFFE);
    tick;
    chk("sat_ffff", 32'(step_count), 32'hFFFF);
    repeat (2) tick;
    chk("sat_hold", 32'(step_count), 32'hFFFF);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
